// File: rtl/weight_double_buffer_pkg.sv
// Shared types and sizing helpers for the weight double buffer.
// The shadow FSM state encoding lives here so sub-modules and checkers agree on it.
package weight_buf_pkg;

  typedef enum logic [1:0] {
    SH_EMPTY = 2'd0,
    SH_FILL  = 2'd1,
    SH_FULL  = 2'd2
  } shadow_state_t;

  // Width of a row count that must be able to hold the value SIZE itself.
  function automatic int row_idx_w(input int size);
    return $clog2(size + 1);
  endfunction

  // Width of a row address within one bank (never narrower than 1 bit).
  function automatic int bank_idx_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/weight_double_buffer_bank.sv
// One SIZE x SIZE weight register bank: a single row write port and the whole array readable.
// The top level owns two of these and ping-pongs between them with a select bit.
module weight_bank
  import weight_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 16,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_row,
  input  logic signed [DATA_WIDTH-1:0] wr_data [SIZE],
  output logic signed [DATA_WIDTH-1:0] rd_data [SIZE][SIZE]
);

  logic signed [DATA_WIDTH-1:0] mem_q [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] mem_d [SIZE][SIZE];

  // Next bank contents: replace the addressed row, hold every other row.
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < SIZE; r++) begin
      if (wr_en && (wr_row == IDX_W'(r))) begin
        mem_d[r] = wr_data;
      end else begin
        mem_d[r] = mem_q[r];
      end
    end
  end

  // Bank storage; cleared on reset so the array never carries X into the PEs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          mem_q[r][c] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/weight_double_buffer.sv
// Weight double buffer between the kernel loader and the weight-stationary array: rows fill the
// shadow bank while the array works on the active bank, and a select bit swaps them per tile.
module weight_double_buffer
  import weight_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         store_weight_req,
  input  logic signed [DATA_WIDTH-1:0] weight_in [SIZE],
  input  logic                         weight_sending_done,
  input  logic                         active_release,
  output logic                         shadow_ready,
  output logic                         shadow_full,
  output logic                         active_valid,
  output logic                         weight_swapped,
  output logic signed [DATA_WIDTH-1:0] pe_weight [SIZE][SIZE],
  output logic [$clog2(SIZE+1)-1:0]    active_rows,
  output logic [CNT_WIDTH-1:0]         tile_cnt,
  output logic                         overflow_err
);

  localparam int ROW_W = row_idx_w(SIZE);
  localparam int IDX_W = bank_idx_w(SIZE);
  localparam logic [ROW_W-1:0] SIZE_ROWS = ROW_W'(SIZE);

  shadow_state_t        state_q, state_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]     shadow_rows_q, shadow_rows_d;
  logic [ROW_W-1:0]     active_rows_q, active_rows_d;
  logic [CNT_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
  logic                 sel_q, sel_d;
  logic                 active_valid_q, active_valid_d;
  logic                 swapped_q, swapped_d;
  logic                 overflow_q, overflow_d;
  logic                 shadow_ready_q, shadow_ready_d;
  logic                 shadow_full_q, shadow_full_d;

  logic can_fill;
  logic row_acc;
  logic row_drop;
  logic done_drop;
  logic swap;
  logic wr_en0;
  logic wr_en1;

  logic signed [DATA_WIDTH-1:0] bank0_rd [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] bank1_rd [SIZE][SIZE];

  // Acceptance, drop and swap decisions, all taken from registered state.
  always_comb begin
    can_fill  = (state_q != SH_FULL);
    row_acc   = store_weight_req && can_fill && (row_cnt_q < SIZE_ROWS);
    row_drop  = store_weight_req && !(can_fill && (row_cnt_q < SIZE_ROWS));
    done_drop = weight_sending_done && !can_fill;
    swap      = (state_q == SH_FULL) && (!active_valid_q || active_release);
    // sel_q names the active bank, so the shadow is always the other one.
    wr_en0    = row_acc && !flush && sel_q;
    wr_en1    = row_acc && !flush && !sel_q;
  end

  // Next-state logic for the shadow FSM, bank select, counters and status flags.
  always_comb begin
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    shadow_rows_d  = shadow_rows_q;
    active_rows_d  = active_rows_q;
    tile_cnt_d     = tile_cnt_q;
    sel_d          = sel_q;
    active_valid_d = active_valid_q;
    swapped_d      = 1'b0;
    overflow_d     = overflow_q | row_drop | done_drop;

    if (swap) begin
      sel_d          = ~sel_q;
      active_valid_d = 1'b1;
      active_rows_d  = shadow_rows_q;
      state_d        = SH_EMPTY;
      row_cnt_d      = {ROW_W{1'b0}};
      tile_cnt_d     = tile_cnt_q + CNT_WIDTH'(1);
      swapped_d      = 1'b1;
    end else begin
      if (active_release) begin
        active_valid_d = 1'b0;
        active_rows_d  = {ROW_W{1'b0}};
      end else begin
        active_valid_d = active_valid_q;
        active_rows_d  = active_rows_q;
      end
      case (state_q)
        SH_EMPTY, SH_FILL: begin
          if (row_acc) begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
            if (weight_sending_done) begin
              state_d       = SH_FULL;
              shadow_rows_d = row_cnt_q + ROW_W'(1);
            end else begin
              state_d = SH_FILL;
            end
          end else if (weight_sending_done) begin
            state_d       = SH_FULL;
            shadow_rows_d = row_cnt_q;
          end else begin
            state_d = state_q;
          end
        end
        SH_FULL: begin
          state_d = SH_FULL;
        end
        default: begin
          state_d   = SH_EMPTY;
          row_cnt_d = {ROW_W{1'b0}};
        end
      endcase
    end

    shadow_ready_d = (state_d == SH_EMPTY);
    shadow_full_d  = (state_d == SH_FULL);
  end

  // Control and status registers; flush behaves exactly like reset and overrides all inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SH_EMPTY;
      row_cnt_q      <= {ROW_W{1'b0}};
      shadow_rows_q  <= {ROW_W{1'b0}};
      active_rows_q  <= {ROW_W{1'b0}};
      tile_cnt_q     <= {CNT_WIDTH{1'b0}};
      sel_q          <= 1'b0;
      active_valid_q <= 1'b0;
      swapped_q      <= 1'b0;
      overflow_q     <= 1'b0;
      shadow_ready_q <= 1'b1;
      shadow_full_q  <= 1'b0;
    end else if (flush) begin
      state_q        <= SH_EMPTY;
      row_cnt_q      <= {ROW_W{1'b0}};
      shadow_rows_q  <= {ROW_W{1'b0}};
      active_rows_q  <= {ROW_W{1'b0}};
      tile_cnt_q     <= {CNT_WIDTH{1'b0}};
      sel_q          <= 1'b0;
      active_valid_q <= 1'b0;
      swapped_q      <= 1'b0;
      overflow_q     <= 1'b0;
      shadow_ready_q <= 1'b1;
      shadow_full_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      shadow_rows_q  <= shadow_rows_d;
      active_rows_q  <= active_rows_d;
      tile_cnt_q     <= tile_cnt_d;
      sel_q          <= sel_d;
      active_valid_q <= active_valid_d;
      swapped_q      <= swapped_d;
      overflow_q     <= overflow_d;
      shadow_ready_q <= shadow_ready_d;
      shadow_full_q  <= shadow_full_d;
    end
  end

  weight_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .IDX_W      (IDX_W)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en0),
    .wr_row  (row_cnt_q[IDX_W-1:0]),
    .wr_data (weight_in),
    .rd_data (bank0_rd)
  );

  weight_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .IDX_W      (IDX_W)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en1),
    .wr_row  (row_cnt_q[IDX_W-1:0]),
    .wr_data (weight_in),
    .rd_data (bank1_rd)
  );

  // Active-bank read with rows beyond the tile height forced to zero.
  always_comb begin
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (ROW_W'(r) < active_rows_q) begin
          pe_weight[r][c] = sel_q ? bank1_rd[r][c] : bank0_rd[r][c];
        end else begin
          pe_weight[r][c] = {DATA_WIDTH{1'b0}};
        end
      end
    end
  end

  assign shadow_ready   = shadow_ready_q;
  assign shadow_full    = shadow_full_q;
  assign active_valid   = active_valid_q;
  assign weight_swapped = swapped_q;
  assign active_rows    = active_rows_q;
  assign tile_cnt       = tile_cnt_q;
  assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_weight_double_buffer.sv
// Table-driven self-checking bench for weight_double_buffer at SIZE=4: each cycle record carries
// its inputs and the outputs expected after that clock edge, queued and compared after the edge.
module tb_weight_double_buffer;

  localparam int DW = 8;
  localparam int SZ = 4;
  localparam int CW = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 store_weight_req;
  logic signed [DW-1:0] weight_in [SZ];
  logic                 weight_sending_done;
  logic                 active_release;
  logic                 shadow_ready;
  logic                 shadow_full;
  logic                 active_valid;
  logic                 weight_swapped;
  logic signed [DW-1:0] pe_weight [SZ][SZ];
  logic [2:0]           active_rows;
  logic [CW-1:0]        tile_cnt;
  logic                 overflow_err;

  weight_double_buffer #(.DATA_WIDTH(DW), .SIZE(SZ), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .store_weight_req    (store_weight_req),
    .weight_in           (weight_in),
    .weight_sending_done (weight_sending_done),
    .active_release      (active_release),
    .shadow_ready        (shadow_ready),
    .shadow_full         (shadow_full),
    .active_valid        (active_valid),
    .weight_swapped      (weight_swapped),
    .pe_weight           (pe_weight),
    .active_rows         (active_rows),
    .tile_cnt            (tile_cnt),
    .overflow_err        (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit store; bit done; bit rel; bit flsh; int tid; int row;
    bit e_rdy; bit e_full; bit e_av; bit e_sw; int e_rows; int e_tcnt; bit e_ovf; int pe_tid;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_no = 0;

  // Tile contents: 1 = 1..16 row-major, 2 = short tile rows of -1/-2, 3 = 40.., 4 = -1..-16.
  function automatic logic signed [DW-1:0] tval(input int id, input int r, input int c);
    int v;
    case (id)
      1: v = r * 4 + c + 1;
      2: v = -(r + 1);
      3: v = 40 + r * 4 + c;
      4: v = -(r * 4 + c + 1);
      default: v = 0;
    endcase
    return DW'(v);
  endfunction

  function automatic vec_t mk(input bit st, input bit dn, input bit rl, input bit fl,
                              input int tid, input int row,
                              input bit rdy, input bit full, input bit av, input bit sw,
                              input int rows, input int tcnt, input bit ovf, input int ptid);
    vec_t v;
    v.store = st; v.done = dn; v.rel = rl; v.flsh = fl; v.tid = tid; v.row = row;
    v.e_rdy = rdy; v.e_full = full; v.e_av = av; v.e_sw = sw;
    v.e_rows = rows; v.e_tcnt = tcnt; v.e_ovf = ovf; v.pe_tid = ptid;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_pe(input string nm, input int ptid, input int rows);
    bit bad = 1'b0;
    int br = 0, bc = 0, ba = 0, be = 0;
    n_cmp++;
    for (int r = 0; r < SZ; r++) begin
      for (int c = 0; c < SZ; c++) begin
        int exp;
        exp = (r < rows) ? int'(tval(ptid, r, c)) : 0;
        if (!bad && (int'(pe_weight[r][c]) != exp)) begin
          bad = 1'b1; br = r; bc = c; ba = int'(pe_weight[r][c]); be = exp;
        end
      end
    end
    if (bad) begin
      n_err++;
      $display("FAIL %s: pe_weight[%0d][%0d] got %0d, expected %0d", nm, br, bc, ba, be);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".shadow_ready"}, int'(shadow_ready), 1);
    chk({tag, ".shadow_full"}, int'(shadow_full), 0);
    chk({tag, ".active_valid"}, int'(active_valid), 0);
    chk({tag, ".weight_swapped"}, int'(weight_swapped), 0);
    chk({tag, ".active_rows"}, int'(active_rows), 0);
    chk({tag, ".tile_cnt"}, int'(tile_cnt), 0);
    chk({tag, ".overflow_err"}, int'(overflow_err), 0);
    chk_pe({tag, ".pe_weight"}, 0, 0);
  endtask

  task automatic drive_idle();
    store_weight_req = 1'b0; weight_sending_done = 1'b0; active_release = 1'b0; flush = 1'b0;
    for (int c = 0; c < SZ; c++) weight_in[c] = 8'sd0;
  endtask

  task automatic check_head();
    vec_t e;
    string tag;
    tag = $sformatf("step%0d", step_no);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s.scoreboard: got empty queue, expected a pending record", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".shadow_ready"}, int'(shadow_ready), int'(e.e_rdy));
      chk({tag, ".shadow_full"}, int'(shadow_full), int'(e.e_full));
      chk({tag, ".active_valid"}, int'(active_valid), int'(e.e_av));
      chk({tag, ".weight_swapped"}, int'(weight_swapped), int'(e.e_sw));
      chk({tag, ".active_rows"}, int'(active_rows), e.e_rows);
      chk({tag, ".tile_cnt"}, int'(tile_cnt), e.e_tcnt);
      chk({tag, ".overflow_err"}, int'(overflow_err), int'(e.e_ovf));
      chk_pe({tag, ".pe_weight"}, e.pe_tid, e.e_rows);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    store_weight_req    = v.store;
    weight_sending_done = v.done;
    active_release      = v.rel;
    flush               = v.flsh;
    for (int c = 0; c < SZ; c++) weight_in[c] = v.store ? tval(v.tid, v.row, c) : 8'sd0;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    check_head();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    //         st dn rl fl tid row | rdy full av sw rows tcnt ovf petid
    // Full tile, then swap into an idle array.
    tbl.push_back(mk(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 4, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4, 1, 0, 1));
    // Overlap: tile 3 waits in the shadow until release.
    tbl.push_back(mk(1, 0, 0, 0, 3, 0,   0, 0, 1, 0, 4, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1,   0, 0, 1, 0, 4, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 2,   0, 0, 1, 0, 4, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 3, 3,   0, 1, 1, 0, 4, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 4, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, 1, 1, 4, 2, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4, 2, 0, 3));
    // Release with nothing pending, then a second release on an idle array.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2, 0, 0));
    // Short tile, done together with the second row.
    tbl.push_back(mk(1, 0, 0, 0, 2, 0,   0, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1,   0, 1, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 2, 3, 0, 2));
    // Overflow: a fifth row, then a row while FULL, both carrying tile-1 data.
    tbl.push_back(mk(1, 0, 0, 0, 4, 0,   0, 0, 1, 0, 2, 3, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 4, 1,   0, 0, 1, 0, 2, 3, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 4, 2,   0, 0, 1, 0, 2, 3, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 4, 3,   0, 0, 1, 0, 2, 3, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2, 3, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 1, 0, 2, 3, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 1, 1, 0, 2, 3, 1, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, 1, 1, 4, 4, 1, 4));
    // Mid-fill flush (asserted together with a row), then a clean reload.
    tbl.push_back(mk(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 4, 4, 1, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4, 4, 1, 4));
    tbl.push_back(mk(1, 0, 0, 1, 1, 2,   1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 4, 1, 0, 1));
    // Two rows of a new tile ahead of an asynchronous reset.
    tbl.push_back(mk(1, 0, 0, 0, 3, 0,   0, 0, 1, 0, 4, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1,   0, 0, 1, 0, 4, 1, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_vals("reset_released");

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Asynchronous reset in mid-cycle after two rows; outputs must drop without a clock edge.
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 0, 0, 4, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 4, 1,   0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 4, 2,   0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 4, 3,   0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 4, 1, 0, 4));
    apply(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4, 1, 0, 4));

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
